// File: rtl/alarm_ctrl_if.sv
// rtl/alarm_ctrl_if.sv - time/keypad inputs and display/buzzer outputs of the alarm stage
interface alarm_ctrl_if;
   logic        CE10;
   logic [31:0] TIME;
   logic        AMODE;
   logic        SETH;
   logic        SETM;
   logic        AEN;
   logic        STOP;
   logic        SNOOZE;
   logic [15:0] ALARM;
   logic        RINGING;
   logic        SNOOZING;
   logic        BUZZ;

   modport master (
      output CE10, TIME, AMODE, SETH, SETM, AEN, STOP, SNOOZE,
      input  ALARM, RINGING, SNOOZING, BUZZ
   );

   modport slave (
      input  CE10, TIME, AMODE, SETH, SETM, AEN, STOP, SNOOZE,
      output ALARM, RINGING, SNOOZING, BUZZ
   );
endinterface

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - settable BCD alarm with minute-boundary trigger, ring/snooze FSM and pulsed buzzer
module alarm_ctrl #(
   parameter int SEC_DIV    = 100,
   parameter int BEEP_ON    = 50,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input logic         CLK,
   input logic         RST,
   alarm_ctrl_if.slave bus
);
   localparam int              PW       = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
   localparam logic [PW-1:0]   PRE_MAX  = PW'(SEC_DIV - 1);
   localparam logic [PW-1:0]   BEEP_LIM = PW'(BEEP_ON);
   localparam logic [8:0]      RING_LIM = 9'(RING_SEC);
   localparam logic [8:0]      SNZ_LIM  = 9'(SNOOZE_SEC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RING = 2'd1,
      SNZ  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [8:0]    sec_q, sec_d, sec_inc;
   logic [7:0]    ah_q, ah_d, am_q, am_d;
   logic          match_q, match_d;
   logic          ringing_q, ringing_d;
   logic          snoozing_q, snoozing_d;
   logic          buzz_q, buzz_d;
   logic          match, trig, tick, state_chg;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == max)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = v + 8'd1;
      return r;
   endfunction

   always_comb begin
      match   = (bus.TIME[31:16] == {ah_q, am_q}) && (bus.TIME[15:0] == 16'h0000);
      match_d = match;
      trig    = match && !match_q;
      tick    = bus.CE10 && (pre_q == PRE_MAX);
      sec_inc = sec_q + 9'd1;

      // Abort conditions outrank STOP, which outranks SNOOZE, which outranks timeout.
      state_d = state_q;
      if (!bus.AEN || bus.AMODE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (trig) state_d = RING;
            RING: begin
               if (bus.STOP)                           state_d = IDLE;
               else if (bus.SNOOZE)                    state_d = SNZ;
               else if (tick && (sec_inc == RING_LIM)) state_d = IDLE;
            end
            SNZ: begin
               if (bus.STOP)                          state_d = IDLE;
               else if (tick && (sec_inc == SNZ_LIM)) state_d = RING;
            end
            default: state_d = IDLE;
         endcase
      end
      state_chg = (state_d != state_q);

      // Idle prescaler parks at 0 so a key press sees a full second before its first step.
      pre_d = pre_q;
      if (state_chg)
         pre_d = '0;
      else if ((state_q == IDLE) && !bus.SETH && !bus.SETM)
         pre_d = '0;
      else if (bus.CE10)
         pre_d = tick ? '0 : pre_q + 1'b1;

      sec_d = sec_q;
      if (state_chg)
         sec_d = '0;
      else if (tick && (state_q != IDLE))
         sec_d = sec_inc;

      ah_d = ah_q;
      am_d = am_q;
      if (tick && (state_q == IDLE) && bus.AMODE) begin
         if (bus.SETH) ah_d = bcd_inc(ah_q, 8'h23);
         if (bus.SETM) am_d = bcd_inc(am_q, 8'h59);
      end

      ringing_d  = (state_d == RING);
      snoozing_d = (state_d == SNZ);
      buzz_d     = (state_d == RING) && (pre_d < BEEP_LIM);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         sec_q      <= '0;
         ah_q       <= 8'h00;
         am_q       <= 8'h00;
         match_q    <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         buzz_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         sec_q      <= sec_d;
         ah_q       <= ah_d;
         am_q       <= am_d;
         match_q    <= match_d;
         ringing_q  <= ringing_d;
         snoozing_q <= snoozing_d;
         buzz_q     <= buzz_d;
      end
   end

   assign bus.ALARM    = {ah_q, am_q};
   assign bus.RINGING  = ringing_q;
   assign bus.SNOOZING = snoozing_q;
   assign bus.BUZZ     = buzz_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed bench for alarm_ctrl with shortened second/ring/snooze timing
module tb_alarm_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alarm_ctrl_if bus();

   alarm_ctrl #(
      .SEC_DIV    (4),
      .BEEP_ON    (2),
      .RING_SEC   (3),
      .SNOOZE_SEC (2)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ce();
      bus.CE10 = 1'b1;
      step(1);
      bus.CE10 = 1'b0;
      step(1);
   endtask

   task automatic ce_n(input int n);
      for (int k = 0; k < n; k++) ce();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic hit_0730();
      bus.TIME = 32'h07295999;
      step(1);
      bus.TIME = 32'h07300000;
      step(1);
   endtask

   task automatic pulse_stop();
      bus.STOP = 1'b1;
      step(1);
      bus.STOP = 1'b0;
   endtask

   task automatic pulse_snooze();
      bus.SNOOZE = 1'b1;
      step(1);
      bus.SNOOZE = 1'b0;
   endtask

   initial begin
      bus.CE10   = 1'b0;
      bus.TIME   = 32'h0;
      bus.AMODE  = 1'b0;
      bus.SETH   = 1'b0;
      bus.SETM   = 1'b0;
      bus.AEN    = 1'b0;
      bus.STOP   = 1'b0;
      bus.SNOOZE = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);

      chk("rst_ringing",  {31'b0, bus.RINGING},  32'd0);
      chk("rst_snoozing", {31'b0, bus.SNOOZING}, 32'd0);
      chk("rst_buzz",     {31'b0, bus.BUZZ},     32'd0);
      chk("rst_alarm",    {16'b0, bus.ALARM},    32'h0);

      // Hour set: first step lands exactly on the 4th CE10 after the press.
      bus.AMODE = 1'b1;
      bus.SETH  = 1'b1;
      ce_n(3);
      chk("seth_early", {16'b0, bus.ALARM}, 32'h0000);
      ce();
      chk("seth_first", {16'b0, bus.ALARM}, 32'h0100);
      for (int i = 2; i <= 24; i++) begin
         ce_n(4);
         chk("seth_seq", {16'b0, bus.ALARM}, {16'b0, bcd8(i % 24), 8'h00});
      end
      bus.SETH = 1'b0;

      for (int i = 1; i <= 90; i++) begin
         bus.SETM = 1'b1;
         ce_n(4);
         chk("setm_seq", {16'b0, bus.ALARM}, {24'b0, bcd8(i % 60)});
      end
      bus.SETM = 1'b0;
      bus.SETH = 1'b1;
      ce_n(28);
      bus.SETH = 1'b0;
      chk("set_0730", {16'b0, bus.ALARM}, 32'h0730);

      bus.AMODE = 1'b0;
      bus.SETH  = 1'b1;
      ce_n(4);
      bus.SETH  = 1'b0;
      chk("seth_no_amode", {16'b0, bus.ALARM}, 32'h0730);

      // Minute-boundary trigger, held TIME gives a single trigger.
      bus.AEN  = 1'b1;
      bus.TIME = 32'h07295999;
      step(2);
      chk("pre_match", {31'b0, bus.RINGING}, 32'd0);
      bus.TIME = 32'h07300000;
      step(1);
      chk("match_ring", {31'b0, bus.RINGING}, 32'd1);
      chk("match_buzz", {31'b0, bus.BUZZ},    32'd1);
      step(5000);
      chk("hold_ring", {31'b0, bus.RINGING}, 32'd1);
      pulse_stop();
      chk("stop_idle", {31'b0, bus.RINGING}, 32'd0);
      step(100);
      chk("no_retrig", {31'b0, bus.RINGING}, 32'd0);

      // Buzzer cadence 1,1,0,0 and timeout after 12 CE10.
      hit_0730();
      chk("ring2", {31'b0, bus.RINGING}, 32'd1);
      for (int k = 1; k <= 12; k++) begin
         ce();
         chk("buzz_pat", {31'b0, bus.BUZZ},    (k < 12 && (k % 4) < 2) ? 32'd1 : 32'd0);
         chk("ring_len", {31'b0, bus.RINGING}, (k < 12) ? 32'd1 : 32'd0);
      end

      // Snooze for 8 CE10 then re-ring, then STOP from snooze.
      hit_0730();
      ce_n(2);
      pulse_snooze();
      chk("snz_on",   {31'b0, bus.SNOOZING}, 32'd1);
      chk("snz_ring", {31'b0, bus.RINGING},  32'd0);
      chk("snz_buzz", {31'b0, bus.BUZZ},     32'd0);
      ce_n(7);
      chk("snz_7", {31'b0, bus.SNOOZING}, 32'd1);
      ce();
      chk("rering",      {31'b0, bus.RINGING},  32'd1);
      chk("rering_snz",  {31'b0, bus.SNOOZING}, 32'd0);
      chk("rering_buzz", {31'b0, bus.BUZZ},     32'd1);
      pulse_snooze();
      chk("snz2", {31'b0, bus.SNOOZING}, 32'd1);
      pulse_stop();
      chk("snz_stop", {31'b0, bus.SNOOZING}, 32'd0);
      chk("snz_stop_r", {31'b0, bus.RINGING}, 32'd0);

      hit_0730();
      bus.STOP   = 1'b1;
      bus.SNOOZE = 1'b1;
      step(1);
      bus.STOP   = 1'b0;
      bus.SNOOZE = 1'b0;
      chk("stop_snz_r", {31'b0, bus.RINGING},  32'd0);
      chk("stop_snz_s", {31'b0, bus.SNOOZING}, 32'd0);

      hit_0730();
      pulse_snooze();
      chk("aen_pre", {31'b0, bus.SNOOZING}, 32'd1);
      bus.AEN = 1'b0;
      step(1);
      chk("aen_drop", {31'b0, bus.SNOOZING}, 32'd0);
      bus.AEN = 1'b1;

      bus.AMODE = 1'b1;
      hit_0730();
      chk("amode_match", {31'b0, bus.RINGING}, 32'd0);
      bus.AMODE = 1'b0;
      step(3);
      chk("amode_after", {31'b0, bus.RINGING}, 32'd0);

      // Reset mid-ring clears everything, alarm back to 00:00.
      hit_0730();
      chk("pre_rst", {31'b0, bus.RINGING}, 32'd1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst_mid_r", {31'b0, bus.RINGING}, 32'd0);
      chk("rst_mid_b", {31'b0, bus.BUZZ},    32'd0);
      chk("rst_mid_a", {16'b0, bus.ALARM},   32'h0);
      hit_0730();
      chk("rst_no_ring", {31'b0, bus.RINGING}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
